// File: rtl/switch_box_cfg_pkg.sv
// Shared types and config-layout helpers for switch_box_cfg.
// The offset functions are the single source of truth for where each field sits in the config word.
package switch_box_cfg_pkg;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } side_e;

  localparam int N_SIDES = 4;

  function automatic int sb_sel_bits(input int n_le);
    return $clog2(n_le + 3);
  endfunction

  function automatic int le_sel_bits(input int width, input int n_le);
    return $clog2(4 * width + n_le);
  endfunction

  function automatic int cfg_bits(input int width, input int n_le, input int le_inputs);
    return N_SIDES * width * sb_sel_bits(n_le)
         + n_le * le_inputs * le_sel_bits(width, n_le)
         + N_SIDES * width;
  endfunction

  function automatic int side_sel_lsb(input int width, input int n_le, input int side, input int i);
    return (side * width + i) * sb_sel_bits(n_le);
  endfunction

  function automatic int le_sel_lsb(input int width, input int n_le, input int le_inputs,
                                    input int le, input int i);
    return N_SIDES * width * sb_sel_bits(n_le) + (le * le_inputs + i) * le_sel_bits(width, n_le);
  endfunction

  function automatic int reg_en_bit(input int width, input int n_le, input int le_inputs,
                                    input int side, input int i);
    return N_SIDES * width * sb_sel_bits(n_le)
         + n_le * le_inputs * le_sel_bits(width, n_le)
         + side * width + i;
  endfunction

endpackage

// File: rtl/switch_box_cfg_mux.sv
// N-input one-bit mux; any select at or above N yields 0.
module switch_box_cfg_mux #(
  parameter int N = 5,
  parameter int S = 3
) (
  input  logic [N-1:0] i_data,
  input  logic [S-1:0] i_sel,
  output logic         o_data
);

  always_comb begin
    o_data = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == S'(k)) o_data = i_data[k];
    end
  end

endmodule

// File: rtl/switch_box_cfg.sv
// Configurable switch box: serial shadow config chain, commit-to-active double buffer,
// per-track side muxes with optional output register, and LE input muxes.
module switch_box_cfg
  import switch_box_cfg_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int N_LE      = 2,
  parameter int LE_INPUTS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            data_north_in,
  input  logic [WIDTH-1:0]            data_east_in,
  input  logic [WIDTH-1:0]            data_south_in,
  input  logic [WIDTH-1:0]            data_west_in,
  output logic [WIDTH-1:0]            data_north_out,
  output logic [WIDTH-1:0]            data_east_out,
  output logic [WIDTH-1:0]            data_south_out,
  output logic [WIDTH-1:0]            data_west_out,
  input  logic [N_LE-1:0]             data_from_les,
  output logic [N_LE*LE_INPUTS-1:0]   data_to_les,
  input  logic                        cfg_in,
  input  logic                        cfg_shift,
  input  logic                        cfg_commit,
  output logic                        cfg_out
);

  localparam int SB_SEL   = sb_sel_bits(N_LE);
  localparam int LE_SEL   = le_sel_bits(WIDTH, N_LE);
  localparam int CFG_BITS = cfg_bits(WIDTH, N_LE, LE_INPUTS);
  localparam int LE_CANDS = 4 * WIDTH + N_LE;

  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;

  // Commit captures the pre-edge shadow even when a shift happens on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (cfg_shift)  r_shadow <= {cfg_in, r_shadow[CFG_BITS-1:1]};
      if (cfg_commit) r_active <= r_shadow;
    end
  end

  assign cfg_out = r_shadow[0];

  logic [WIDTH-1:0] w_side_in  [N_SIDES];
  logic [WIDTH-1:0] w_side_out [N_SIDES];

  assign w_side_in[NORTH] = data_north_in;
  assign w_side_in[EAST]  = data_east_in;
  assign w_side_in[SOUTH] = data_south_in;
  assign w_side_in[WEST]  = data_west_in;

  assign data_north_out = w_side_out[NORTH];
  assign data_east_out  = w_side_out[EAST];
  assign data_south_out = w_side_out[SOUTH];
  assign data_west_out  = w_side_out[WEST];

  // A comes from the next side clockwise, B from the opposite side, C from the previous side.
  for (genvar gs = 0; gs < N_SIDES; gs++) begin : g_side
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_track
      localparam int A_SIDE = (gs + 1) % N_SIDES;
      localparam int B_SIDE = (gs + 2) % N_SIDES;
      localparam int C_SIDE = (gs + 3) % N_SIDES;
      localparam int A_IDX  = (gs == 0) ? (WIDTH - gi) % WIDTH :
                              (gs == 2) ? (2 * WIDTH - 2 - gi) % WIDTH : (gi + 1) % WIDTH;
      localparam int C_IDX  = (gs == 1) ? (WIDTH - gi) % WIDTH :
                              (gs == 3) ? (2 * WIDTH - 2 - gi) % WIDTH : (gi + 1) % WIDTH;
      localparam int SEL_LSB = side_sel_lsb(WIDTH, N_LE, gs, gi);
      localparam int EN_BIT  = reg_en_bit(WIDTH, N_LE, LE_INPUTS, gs, gi);

      logic [N_LE+2:0] w_cand;
      logic            w_mux;
      logic            r_q;

      assign w_cand = {w_side_in[C_SIDE][C_IDX], w_side_in[B_SIDE][gi],
                       w_side_in[A_SIDE][A_IDX], data_from_les};

      switch_box_cfg_mux #(.N(N_LE + 3), .S(SB_SEL)) u_mux (
        .i_data (w_cand),
        .i_sel  (r_active[SEL_LSB +: SB_SEL]),
        .o_data (w_mux)
      );

      always_ff @(posedge clock or posedge reset) begin
        if (reset) r_q <= 1'b0;
        else       r_q <= w_mux;
      end

      assign w_side_out[gs][gi] = r_active[EN_BIT] ? r_q : w_mux;
    end
  end

  logic [LE_CANDS-1:0] w_le_cand;
  assign w_le_cand = {data_north_in, data_east_in, data_south_in, data_west_in, data_from_les};

  for (genvar gl = 0; gl < N_LE; gl++) begin : g_le
    for (genvar gi = 0; gi < LE_INPUTS; gi++) begin : g_in
      localparam int SEL_LSB = le_sel_lsb(WIDTH, N_LE, LE_INPUTS, gl, gi);

      switch_box_cfg_mux #(.N(LE_CANDS), .S(LE_SEL)) u_mux (
        .i_data (w_le_cand),
        .i_sel  (r_active[SEL_LSB +: LE_SEL]),
        .o_data (data_to_les[gl*LE_INPUTS + gi])
      );
    end
  end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Randomized scoreboard bench for switch_box_cfg against a rule-level reference model.
`timescale 1ns/1ps
module tb_switch_box_cfg;

  localparam int W = 6, NL = 2, LI = 4;
  localparam int SB = 3, LS = 5, CFG = 136;
  localparam int LE_BASE = 72, EN_BASE = 112;

  logic clock = 1'b0;
  logic reset;
  logic [W-1:0] n_in, e_in, s_in, w_in;
  logic [W-1:0] n_out, e_out, s_out, w_out;
  logic [NL-1:0] les;
  logic [NL*LI-1:0] to_les;
  logic cfg_in, cfg_shift, cfg_commit, cfg_out;

  always #5 clock = ~clock;

  switch_box_cfg #(.WIDTH(W), .N_LE(NL), .LE_INPUTS(LI)) dut (
    .clock(clock), .reset(reset),
    .data_north_in(n_in), .data_east_in(e_in), .data_south_in(s_in), .data_west_in(w_in),
    .data_north_out(n_out), .data_east_out(e_out), .data_south_out(s_out), .data_west_out(w_out),
    .data_from_les(les), .data_to_les(to_les),
    .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_commit(cfg_commit), .cfg_out(cfg_out)
  );

  typedef struct {
    int          field;
    logic [63:0] exp;
    int          cyc;
  } sb_t;

  sb_t   sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string fname[6] = '{"north_out", "east_out", "south_out", "west_out", "to_les", "cfg_out"};

  // Reference state: shadow chain, active copy, side output flops.
  bit [CFG-1:0] m_shadow, m_active;
  bit [W-1:0]   m_reg[4];

  function automatic int field_of(bit [CFG-1:0] v, int lsb, int w);
    int r = 0;
    for (int b = 0; b < w; b++) r |= int'(v[lsb+b]) << b;
    return r;
  endfunction

  function automatic bit [CFG-1:0] put(bit [CFG-1:0] v, int lsb, int w, int val);
    bit [CFG-1:0] r = v;
    for (int b = 0; b < w; b++) r[lsb+b] = bit'((val >> b) & 1);
    return r;
  endfunction

  // Side routing straight from the candidate table: les, then A, B, C.
  function automatic bit side_comb(int s, int i, bit [CFG-1:0] act);
    int sel = field_of(act, (s*W + i)*SB, SB);
    bit a, b, c;
    case (s)
      0: begin a = e_in[(W-i)%W];     b = s_in[i]; c = w_in[(i+1)%W];     end
      1: begin a = s_in[(i+1)%W];     b = w_in[i]; c = n_in[(W-i)%W];     end
      2: begin a = w_in[(2*W-2-i)%W]; b = n_in[i]; c = e_in[(i+1)%W];     end
      default: begin a = n_in[(i+1)%W]; b = e_in[i]; c = s_in[(2*W-2-i)%W]; end
    endcase
    if (sel < NL) return les[sel];
    case (sel - NL)
      0: return a;
      1: return b;
      2: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit le_comb(int le, int i, bit [CFG-1:0] act);
    int sel = field_of(act, LE_BASE + (le*LI + i)*LS, LS);
    if (sel < NL) return les[sel];
    sel -= NL;
    if (sel < W)   return w_in[sel];
    if (sel < 2*W) return s_in[sel-W];
    if (sel < 3*W) return e_in[sel-2*W];
    if (sel < 4*W) return n_in[sel-3*W];
    return 1'b0;
  endfunction

  task automatic push(int f, logic [63:0] v);
    sb_t e;
    e.field = f; e.exp = v; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic expect_all();
    logic [63:0] v;
    for (int s = 0; s < 4; s++) begin
      v = '0;
      for (int i = 0; i < W; i++)
        v[i] = m_active[EN_BASE + s*W + i] ? m_reg[s][i] : side_comb(s, i, m_active);
      push(s, v);
    end
    v = '0;
    for (int le = 0; le < NL; le++)
      for (int i = 0; i < LI; i++) v[le*LI + i] = le_comb(le, i, m_active);
    push(4, v);
    push(5, {63'd0, m_shadow[0]});
  endtask

  task automatic model_clear();
    m_shadow = '0;
    m_active = '0;
    for (int s = 0; s < 4; s++) m_reg[s] = '0;
  endtask

  task automatic tick();
    bit [CFG-1:0] nsh, nact;
    bit [W-1:0]   nreg[4];
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < W; i++) nreg[s][i] = side_comb(s, i, m_active);
    nsh  = cfg_shift  ? {cfg_in, m_shadow[CFG-1:1]} : m_shadow;
    nact = cfg_commit ? m_shadow : m_active;
    @(posedge clock);
    if (reset) model_clear();
    else begin
      m_shadow = nsh;
      m_active = nact;
      for (int s = 0; s < 4; s++) m_reg[s] = nreg[s];
    end
    cyc++;
    #1;
  endtask

  task automatic rand_inputs(bit keep_les);
    n_in = W'($urandom); e_in = W'($urandom); s_in = W'($urandom); w_in = W'($urandom);
    if (!keep_les) les = NL'($urandom);
  endtask

  task automatic cycle();
    expect_all();
    tick();
  endtask

  task automatic load(bit [CFG-1:0] v);
    cfg_shift = 1'b1;
    for (int j = 0; j < CFG; j++) begin
      cfg_in = v[j];
      rand_inputs(1'b0);
      cycle();
    end
    cfg_shift = 1'b0;
  endtask

  task automatic commit_and_run(int n);
    cfg_commit = 1'b1;
    rand_inputs(1'b0);
    cycle();
    cfg_commit = 1'b0;
    for (int k = 0; k < n; k++) begin
      rand_inputs(1'b0);
      cycle();
    end
  endtask

  function automatic bit [CFG-1:0] rand_cfg();
    bit [CFG-1:0] v;
    for (int j = 0; j < CFG; j++) v[j] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Monitor: drains the scoreboard on each falling edge, away from the active edge.
  initial begin
    sb_t e;
    logic [63:0] act;
    forever begin
      @(negedge clock);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.field)
          0: act = 64'(n_out);
          1: act = 64'(e_out);
          2: act = 64'(s_out);
          3: act = 64'(w_out);
          4: act = 64'(to_les);
          default: act = 64'(cfg_out);
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", fname[e.field], e.cyc, act, e.exp);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [CFG-1:0] c1, c2, pat;

    reset = 1'b1; cfg_in = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0;
    n_in = '0; e_in = '0; s_in = '0; w_in = '0; les = 2'b01;
    model_clear();
    #1;
    $display("[TB] reset and idle with les=01");
    repeat (3) begin rand_inputs(1'b1); cycle(); end
    reset = 1'b0;
    repeat (4) begin rand_inputs(1'b1); cycle(); end

    $display("[TB] async reset in the middle of shifting");
    cfg_shift = 1'b1;
    repeat (10) begin cfg_in = 1'b1; rand_inputs(1'b0); cycle(); end
    cfg_in = 1'b1;
    #2;
    reset = 1'b1;
    model_clear();
    expect_all();
    tick();
    reset = 1'b0;
    cfg_shift = 1'b0;
    repeat (3) begin rand_inputs(1'b0); cycle(); end

    $display("[TB] directed config: north0=B, east2=C registered, south1=7, le0_i1=31");
    c1 = rand_cfg();
    c1 = put(c1, (0*W + 0)*SB, SB, 3);
    c1 = put(c1, EN_BASE + 0*W + 0, 1, 0);
    c1 = put(c1, (1*W + 2)*SB, SB, 4);
    c1 = put(c1, EN_BASE + 1*W + 2, 1, 1);
    c1 = put(c1, (2*W + 1)*SB, SB, 7);
    c1 = put(c1, EN_BASE + 2*W + 1, 1, 0);
    c1 = put(c1, LE_BASE + (0*LI + 1)*LS, LS, 31);
    load(c1);
    commit_and_run(40);

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random config %0d", r);
      load(rand_cfg());
      commit_and_run(30);
    end

    $display("[TB] shift and commit on the same edge");
    c2 = rand_cfg();
    load(c2);
    cfg_shift = 1'b1; cfg_commit = 1'b1; cfg_in = 1'($urandom_range(0, 1));
    rand_inputs(1'b0);
    cycle();
    cfg_shift = 1'b0; cfg_commit = 1'b0;
    repeat (20) begin rand_inputs(1'b0); cycle(); end

    $display("[TB] chain pass-through of a %0d-bit pattern", CFG);
    pat = rand_cfg();
    load(pat);
    load('0);
    repeat (2) begin rand_inputs(1'b0); cycle(); end

    @(negedge clock);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
